// File: rtl/alu_ctrl_stage.sv
// ID/EX stage: decodes an RV32I instruction into ALU control, operands and
// sideband flags, registered behind a valid/ready handshake with skid buffer.
// Ports: clk_i/rst_n_i, flush_i, valid_i/ready_o + instr_i, pc_i, rs1/rs2 data
// in; valid_o/ready_i + ALUCtrl_o, data1/2, imm, rs2_data, rd, flags out.
module alu_ctrl_stage #(
  parameter bit SKID_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [3:0]  ALUCtrl_o,
  output logic [31:0] data1_o,
  output logic [31:0] data2_o,
  output logic [31:0] imm_o,
  output logic [31:0] rs2_data_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        branch_o,
  output logic        jump_o,
  output logic        illegal_o
);

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jp;
    logic        ill;
  } ex_t;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] AND = 4'd2;
  localparam logic [3:0] OR  = 4'd3;
  localparam logic [3:0] SLT = 4'd4;
  localparam logic [3:0] XOR = 4'd5;
  localparam logic [3:0] SLL = 4'd6;
  localparam logic [3:0] SRL = 4'd7;
  localparam logic [3:0] SRA = 4'd8;
  localparam logic [3:0] BNE = 4'd9;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_OPI = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JLR = 7'b1100111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_op;
  logic        is_opi;
  logic        f7_zero;
  logic        f7_alt;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] j_imm;

  assign opc     = instr_i[6:0];
  assign f3      = instr_i[14:12];
  assign f7      = instr_i[31:25];
  assign is_op   = opc == OPC_OP;
  assign is_opi  = opc == OPC_OPI;
  assign f7_zero = f7 == 7'b0000000;
  assign f7_alt  = f7 == 7'b0100000;

  assign i_imm = {{20{instr_i[31]}}, instr_i[31:20]};
  assign s_imm = {{20{instr_i[31]}}, instr_i[31:25],
                  instr_i[11:7]};
  assign b_imm = {{19{instr_i[31]}}, instr_i[31],
                  instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign j_imm = {{11{instr_i[31]}}, instr_i[31],
                  instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  // Shared funct3 map for OP and OP-IMM.
  // In OP-IMM funct7 is immediate bits except for shifts.
  logic [3:0] ar_alu;
  logic       ar_ok;

  always_comb begin
    ar_alu = ADD;
    ar_ok  = 1'b1;
    unique case (f3)
      3'b000: begin
        ar_alu = (is_op && f7_alt) ? SUB : ADD;
        ar_ok  = !is_op || f7_zero || f7_alt;
      end
      3'b001: begin
        ar_alu = SLL;
        ar_ok  = f7_zero;
      end
      3'b010: begin
        ar_alu = SLT;
        ar_ok  = !is_op || f7_zero;
      end
      3'b011: ar_ok = 1'b0;
      3'b100: begin
        ar_alu = XOR;
        ar_ok  = !is_op || f7_zero;
      end
      3'b101: begin
        ar_alu = f7_alt ? SRA : SRL;
        ar_ok  = f7_zero || f7_alt;
      end
      3'b110: begin
        ar_alu = OR;
        ar_ok  = !is_op || f7_zero;
      end
      3'b111: begin
        ar_alu = AND;
        ar_ok  = !is_op || f7_zero;
      end
      default: ar_ok = 1'b0;
    endcase
  end

  ex_t dec;

  always_comb begin
    dec     = '0;
    dec.alu = ADD;
    dec.d1  = rs1_data_i;
    dec.d2  = rs2_data_i;
    dec.st  = rs2_data_i;
    dec.rd  = instr_i[11:7];
    unique case (1'b1)
      is_op: begin
        dec.alu = ar_alu;
        dec.rw  = 1'b1;
        dec.ill = !ar_ok;
      end
      is_opi: begin
        dec.alu = ar_alu;
        dec.rw  = 1'b1;
        dec.ill = !ar_ok;
        if (f3 == 3'b001 || f3 == 3'b101)
          dec.d2 = {27'd0, instr_i[24:20]};
        else
          dec.d2 = i_imm;
      end
      (opc == OPC_LD): begin
        dec.d2  = i_imm;
        dec.mr  = 1'b1;
        dec.rw  = 1'b1;
        dec.ill = f3 != 3'b010;
      end
      (opc == OPC_ST): begin
        dec.d2  = s_imm;
        dec.mw  = 1'b1;
        dec.ill = f3 != 3'b010;
      end
      (opc == OPC_BR): begin
        dec.alu = f3[0] ? BNE : XOR;
        dec.imm = b_imm;
        dec.br  = 1'b1;
        dec.ill = f3[2:1] != 2'b00;
      end
      (opc == OPC_JLR): begin
        dec.d2  = i_imm;
        dec.jp  = 1'b1;
        dec.rw  = 1'b1;
        dec.ill = f3 != 3'b000;
      end
      (opc == OPC_JAL): begin
        dec.d1  = pc_i;
        dec.d2  = 32'd4;
        dec.imm = j_imm;
        dec.jp  = 1'b1;
        dec.rw  = 1'b1;
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal entries still flow but must have no side effects.
    if (dec.ill) begin
      dec.alu = ADD;
      dec.rw  = 1'b0;
      dec.mr  = 1'b0;
      dec.mw  = 1'b0;
      dec.br  = 1'b0;
      dec.jp  = 1'b0;
    end
    if (dec.rd == 5'd0)
      dec.rw = 1'b0;
  end

  ex_t  out_q;
  ex_t  skid_q;
  logic out_v;
  logic skid_v;
  logic acc;
  logic ret;

  // Ready depends only on state when the skid is enabled.
  assign ready_o = SKID_EN ? !skid_v
                           : (!out_v || ready_i);
  assign acc     = valid_i && ready_o;
  assign ret     = out_v && ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush_i) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || ret) begin
      // ready_o is low whenever skid is full, so no accept here then.
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        if (acc)
          out_q <= dec;
        out_v <= acc;
      end
    end else if (acc && SKID_EN) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign valid_o     = out_v;
  assign ALUCtrl_o   = out_q.alu;
  assign data1_o     = out_q.d1;
  assign data2_o     = out_q.d2;
  assign imm_o       = out_q.imm;
  assign rs2_data_o  = out_q.st;
  assign rd_o        = out_q.rd;
  assign reg_write_o = out_q.rw;
  assign mem_read_o  = out_q.mr;
  assign mem_write_o = out_q.mw;
  assign branch_o    = out_q.br;
  assign jump_o      = out_q.jp;
  assign illegal_o   = out_q.ill;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Testbench for alu_ctrl_stage: decode vectors through the handshake,
// then back-pressure, flush and asynchronous reset sequences.
module tb_alu_ctrl_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  alu;
  logic [31:0] d1;
  logic [31:0] d2;
  logic [31:0] imm;
  logic [31:0] st;
  logic [4:0]  rd;
  logic        rw, mr, mw, br, jp, ill;
  logic [5:0]  flags;

  int checks = 0;
  int errors = 0;

  assign flags = {rw, mr, mw, br, jp, ill};

  alu_ctrl_stage #(.SKID_EN(1'b1)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .instr_i     (instr),
    .pc_i        (pc),
    .rs1_data_i  (rs1),
    .rs2_data_i  (rs2),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .ALUCtrl_o   (alu),
    .data1_o     (d1),
    .data2_o     (d2),
    .imm_o       (imm),
    .rs2_data_o  (st),
    .rd_o        (rd),
    .reg_write_o (rw),
    .mem_read_o  (mr),
    .mem_write_o (mw),
    .branch_o    (br),
    .jump_o      (jp),
    .illegal_o   (ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  alu;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [5:0]  fl;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] ins,
                       input logic [31:0] a);
    valid_i = v;
    instr   = ins;
    pc      = 32'h0;
    rs1     = a;
    rs2     = 32'h0;
  endtask

  initial begin
    // flags = {rw, mr, mw, br, jp, ill}
    vecs[0]  = '{32'hFFF10093, 0, 5, 0,
                 0, 5, 32'hFFFFFFFF, 0, 1, 6'b100000};
    vecs[1]  = '{32'h402081B3, 0, 10, 3,
                 1, 10, 3, 0, 3, 6'b100000};
    vecs[2]  = '{32'h40335293, 0, 32'h80000000, 7,
                 8, 32'h80000000, 3, 0, 5, 6'b100000};
    vecs[3]  = '{32'h00209463, 0, 1, 32'h1234,
                 9, 1, 32'h1234, 8, 8, 6'b000100};
    vecs[4]  = '{32'h00208463, 0, 2, 3,
                 5, 2, 3, 8, 8, 6'b000100};
    vecs[5]  = '{32'h0062F233, 0, 32'hF0F0, 32'hFF00,
                 2, 32'hF0F0, 32'hFF00, 0, 4, 6'b100000};
    vecs[6]  = '{32'h0062E233, 0, 1, 2,
                 3, 1, 2, 0, 4, 6'b100000};
    vecs[7]  = '{32'h7FF0C393, 0, 9, 9,
                 5, 9, 32'h7FF, 0, 7, 6'b100000};
    vecs[8]  = '{32'h8000A393, 0, 9, 9,
                 4, 9, 32'hFFFFF800, 0, 7, 6'b100000};
    vecs[9]  = '{32'h01F09393, 0, 1, 0,
                 6, 1, 31, 0, 7, 6'b100000};
    vecs[10] = '{32'h0020D3B3, 0, 32'h80, 4,
                 7, 32'h80, 4, 0, 7, 6'b100000};
    vecs[11] = '{32'hFFC12403, 0, 32'h100, 5,
                 0, 32'h100, 32'hFFFFFFFC, 0, 8, 6'b110000};
    vecs[12] = '{32'h00312623, 0, 32'h200, 32'hCAFE,
                 0, 32'h200, 12, 0, 12, 6'b001000};
    vecs[13] = '{32'h010000EF, 32'h100, 7, 8,
                 0, 32'h100, 4, 16, 1, 6'b100010};
    vecs[14] = '{32'hFFDFF06F, 32'h40, 7, 8,
                 0, 32'h40, 4, 32'hFFFFFFFC, 0, 6'b000010};
    vecs[15] = '{32'h004280E7, 0, 32'h1000, 8,
                 0, 32'h1000, 4, 0, 1, 6'b100010};
    vecs[16] = '{32'h000000FF, 0, 3, 4,
                 0, 3, 4, 0, 1, 6'b000001};
    vecs[17] = '{32'h0020B3B3, 0, 3, 4,
                 0, 3, 4, 0, 7, 6'b000001};
    vecs[18] = '{32'h4062F233, 0, 3, 4,
                 0, 3, 4, 0, 4, 6'b000001};
    vecs[19] = '{32'hFE209CE3, 0, 6, 6,
                 9, 6, 6, 32'hFFFFFFF8, 25, 6'b000100};

    rst_n   = 1'b0;
    flush   = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    cyc();
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_ready", {31'd0, ready_o}, 1);
    chk("rst_alu", {28'd0, alu}, 0);
    chk("rst_d1", d1, 0);
    chk("rst_flags", {26'd0, flags}, 0);
    rst_n = 1'b1;
    cyc();

    // Decode table, one accept per cycle with EX always ready.
    for (int i = 0; i < 20; i++) begin
      valid_i = 1'b1;
      instr   = vecs[i].instr;
      pc      = vecs[i].pc;
      rs1     = vecs[i].rs1;
      rs2     = vecs[i].rs2;
      cyc();
      chk($sformatf("v%0d_valid", i), {31'd0, valid_o}, 1);
      chk($sformatf("v%0d_alu", i), {28'd0, alu},
          {28'd0, vecs[i].alu});
      chk($sformatf("v%0d_d1", i), d1, vecs[i].d1);
      chk($sformatf("v%0d_d2", i), d2, vecs[i].d2);
      chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
      chk($sformatf("v%0d_st", i), st, vecs[i].rs2);
      chk($sformatf("v%0d_rd", i), {27'd0, rd},
          {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_flags", i), {26'd0, flags},
          {26'd0, vecs[i].fl});
    end
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    chk("idle_valid", {31'd0, valid_o}, 0);

    // Back-pressure: A, B, C with EX stalled.
    ready_i = 1'b0;
    drive(1'b1, 32'hFFF10093, 32'hA);
    cyc();
    chk("bp_a_valid", {31'd0, valid_o}, 1);
    chk("bp_a_ready", {31'd0, ready_o}, 1);
    drive(1'b1, 32'hFFF10093, 32'hB);
    cyc();
    chk("bp_ready_fall", {31'd0, ready_o}, 0);
    chk("bp_hold_a", d1, 32'hA);
    drive(1'b1, 32'hFFF10093, 32'hC);
    cyc();
    chk("bp_hold_a2", d1, 32'hA);
    chk("bp_ready_low", {31'd0, ready_o}, 0);
    ready_i = 1'b1;
    cyc();
    chk("bp_out_b", d1, 32'hB);
    chk("bp_ready_back", {31'd0, ready_o}, 1);
    cyc();
    chk("bp_out_c", d1, 32'hC);
    chk("bp_c_valid", {31'd0, valid_o}, 1);
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    chk("bp_drain", {31'd0, valid_o}, 0);

    // Flush with both entries full and an incoming instruction.
    ready_i = 1'b0;
    drive(1'b1, 32'hFFF10093, 32'h11);
    cyc();
    drive(1'b1, 32'hFFF10093, 32'h22);
    cyc();
    chk("fl_full", {31'd0, ready_o}, 0);
    drive(1'b1, 32'hFFF10093, 32'h33);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_valid", {31'd0, valid_o}, 0);
    chk("fl_ready", {31'd0, ready_o}, 1);
    // Flush when only the output is held: the accept is dropped.
    drive(1'b1, 32'hFFF10093, 32'h44);
    cyc();
    chk("fl2_valid", {31'd0, valid_o}, 1);
    drive(1'b1, 32'hFFF10093, 32'h55);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    ready_i = 1'b1;
    chk("fl2_dropped", {31'd0, valid_o}, 0);
    cyc();
    chk("fl2_stay_empty", {31'd0, valid_o}, 0);
    drive(1'b1, 32'hFFF10093, 32'h66);
    cyc();
    chk("fl_next_data", d1, 32'h66);
    drive(1'b0, 32'h0, 32'h0);

    // Asynchronous reset mid-stream with a held entry.
    ready_i = 1'b0;
    drive(1'b1, 32'hFFF10093, 32'h77);
    cyc();
    drive(1'b1, 32'hFFF10093, 32'h88);
    cyc();
    chk("ar_pre_valid", {31'd0, valid_o}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, valid_o}, 0);
    chk("ar_ready", {31'd0, ready_o}, 1);
    chk("ar_d1", d1, 0);
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    rst_n   = 1'b1;
    ready_i = 1'b1;
    cyc();
    chk("ar_after", {31'd0, valid_o}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- ID/EX boundary stage that produces the ALU's inputs. It decodes an expanded 32-bit RV32I instruction into the 4-bit ALU control code, both ALU operands and memory/writeback/branch sideband bits.
- Outputs are registered behind a valid/ready handshake with a 2-entry skid buffer, so EX back-pressure never forms a combinational path into decode.

Parameters:
SKID_EN, 1, 1 = 2-entry skid buffer with registered ready_o; 0 = single register, ready_o = !valid_o | ready_i

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous reset, active-low
flush_i  input  1  kill all held entries (branch taken / jump)
valid_i  input  1  instr_i and the operand inputs are valid
ready_o  output  1  stage can accept
instr_i  input  32  expanded (non-compressed) instruction
pc_i  input  32  instruction PC
rs1_data_i  input  32  register-file read data for rs1
rs2_data_i  input  32  register-file read data for rs2
valid_o  output  1  outputs hold a decoded instruction
ready_i  input  1  EX accepts
ALUCtrl_o  output  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 BNE
data1_o  output  32  ALU operand 1
data2_o  output  32  ALU operand 2
imm_o  output  32  B/J offset for the PC adder, sign-extended
rs2_data_o  output  32  store data
rd_o  output  5  destination register
reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o  output  1 each  sideband flags

Behaviour:
- Reset: valid_o=0, ready_o=1, every data/control output 0, skid empty.
- Transfers: accept on valid_i&ready_o. Retire on valid_o&ready_i. Latency is 1 cycle from accept to valid_o.
- Output register: when empty, or when it retires in the same cycle, it loads the skid entry if one is present, otherwise the incoming instruction.
- Skid buffer: an accept while the output is held and not retiring goes to the skid. ready_o = !skid_valid, taken from a register.
- Ordering: strict FIFO. Accept and retire in the same cycle with the skid full cannot happen, because ready_o=0.
- flush_i has priority over everything. Next cycle: valid_o=0, skid empty, and any instruction accepted in the flush cycle is dropped.
- Reset mid-operation clears all state immediately.
- Decode by opcode:
  - OP (0110011) → rs1/rs2. funct3 000 gives ADD, or SUB when funct7=0100000. 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL/SRA selected by funct7[5]. reg_write=1.
  - OP-IMM (0010011): data2 = sext(instr[31:20]), same funct3 map. Shifts use data2 = zext(instr[24:20]); SRAI when instr[30]=1.
  - LOAD with funct3 010: ADD, data2 = I-imm, mem_read=1, reg_write=1.
  - STORE with funct3 010: ADD, data2 = sext({instr[31:25],instr[11:7]}), mem_write=1.
  - BRANCH: funct3 000 → XOR (BEQ), 001 → BNE. data2 = rs2. branch_o=1. imm_o = B-imm.
  - JALR: ADD rs1+I-imm, jump_o=1, reg_write=1.
  - JAL: data1 = pc_i, data2 = 4, ADD, imm_o = J-imm, jump_o=1, reg_write=1.
- Operand default: data1 = rs1_data_i except JAL.
- Illegal cases: any other opcode, funct3 or funct7 combination gives illegal_o=1, ALUCtrl_o=ADD, and reg_write, mem_* and branch/jump flags all 0. Such entries still flow through the handshake.
- rd == x0: reg_write_o is forced to 0.
- All outputs hold stable while valid_o&!ready_i.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), rs1_data=5, ready_i=1 → next cycle valid_o=1, ALUCtrl_o=0, data1_o=5, data2_o=0xFFFFFFFF, rd_o=1, reg_write_o=1.
- SUB x3,x1,x2 (0x402081B3) → ALUCtrl_o=1. SRAI x5,x6,3 (0x40335293) → ALUCtrl_o=8, data2_o=3.
- BNE x1,x2,+8 (0x00209463) → ALUCtrl_o=9, branch_o=1, imm_o=8, data2_o=rs2_data_i, reg_write_o=0.
- Back-pressure: three back-to-back valid_i with ready_i=0 → ready_o falls after the 2nd accept. Release ready_i → the 3 instructions exit in order with no loss or duplication.
- flush_i while both entries are full and valid_i=1 → next cycle valid_o=0, ready_o=1, the dropped instruction never appears.
- Opcode 0x7F, and rst_n_i low mid-stream → illegal_o=1 with all write flags 0. Reset clears valid_o asynchronously with no clock edge needed.
